// File: rtl/game_state_regs.sv
// rtl/game_state_regs.sv - round timer FSM plus score, fruit and lives registers
module game_state_regs #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECONDS  = 120
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        restart,
    input  logic        lifeDown,
    input  logic        win,
    input  logic        lose,
    input  logic        Load_S,
    input  logic [9:0]  score_in,
    input  logic        Load_F,
    input  logic [3:0]  fruits_in,
    input  logic        Load_L,
    input  logic [7:0]  lives_in,
    output logic [9:0]  score_out,
    output logic [3:0]  fruits_out,
    output logic [1:0]  lives_out,
    output logic [31:0] counter,
    output logic [7:0]  seconds_left,
    output logic        time_up,
    output logic        running
);

    localparam logic [31:0] FULL_COUNT = 32'(ROUND_SECONDS * FRAMES_PER_SEC);
    localparam logic [7:0]  FULL_SEC   = 8'(ROUND_SECONDS);
    localparam logic [7:0]  PRE_LAST   = 8'(FRAMES_PER_SEC - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        HOLD,
        EXPIRED,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] prescaler;
    logic       do_tick;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority restart > win/lose > lifeDown > frame_tick falls out of the branch order.
    always_comb begin
        state_next = state;
        do_tick    = 1'b0;
        if (restart) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_next = RUN;
                end
                RUN: begin
                    if (win || lose) begin
                        state_next = DONE;
                    end else if (lifeDown) begin
                        state_next = HOLD;
                    end else if (frame_tick && counter != 32'd0) begin
                        do_tick = 1'b1;
                        if (counter == 32'd1) state_next = EXPIRED;
                    end
                end
                HOLD: begin
                    if (win || lose) begin
                        state_next = DONE;
                    end else if (!lifeDown) begin
                        state_next = RUN;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            counter      <= FULL_COUNT;
            seconds_left <= FULL_SEC;
            prescaler    <= 8'd0;
            time_up      <= 1'b0;
            running      <= 1'b0;
        end else begin
            running <= (state_next == RUN);
            time_up <= 1'b0;
            if (restart) begin
                counter      <= FULL_COUNT;
                seconds_left <= FULL_SEC;
                prescaler    <= 8'd0;
            end else if (do_tick) begin
                counter <= counter - 32'd1;
                if (counter == 32'd1) begin
                    seconds_left <= 8'd0;
                    prescaler    <= 8'd0;
                    time_up      <= 1'b1;
                end else if (prescaler == PRE_LAST) begin
                    prescaler    <= 8'd0;
                    seconds_left <= seconds_left - 8'd1;
                end else begin
                    prescaler <= prescaler + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_out  <= 10'd0;
            fruits_out <= 4'd0;
            lives_out  <= 2'd0;
        end else if (restart) begin
            score_out  <= 10'd0;
            fruits_out <= 4'd0;
            lives_out  <= 2'd0;
        end else begin
            if (Load_S) score_out <= score_in;
            if (Load_F) fruits_out <= fruits_out | fruits_in;
            if (Load_L) lives_out <= (lives_in > 8'd3) ? 2'd3 : lives_in[1:0];
        end
    end

endmodule

// File: tb/tb_game_state_regs.sv
// tb/tb_game_state_regs.sv - directed bench with a behavioural round model for game_state_regs
module tb_game_state_regs;

    localparam int FPS = 4;
    localparam int RS  = 3;
    localparam int FULL = FPS * RS;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_OVER = 3;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_tick = 1'b0, start = 1'b0, restart = 1'b0, lifeDown = 1'b0;
    logic        win = 1'b0, lose = 1'b0;
    logic        Load_S = 1'b0, Load_F = 1'b0, Load_L = 1'b0;
    logic [9:0]  score_in = '0;
    logic [3:0]  fruits_in = '0;
    logic [7:0]  lives_in = '0;
    logic [9:0]  score_out;
    logic [3:0]  fruits_out;
    logic [1:0]  lives_out;
    logic [31:0] counter;
    logic [7:0]  seconds_left;
    logic        time_up, running;

    int passed = 0;
    int total  = 0;
    bit armed  = 1'b0;

    int m_phase   = PH_IDLE;
    int m_counter = FULL;
    int m_score   = 0;
    int m_fruits  = 0;
    int m_lives   = 0;
    bit m_time_up = 1'b0;

    game_state_regs #(.FRAMES_PER_SEC(FPS), .ROUND_SECONDS(RS)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
        .restart(restart), .lifeDown(lifeDown), .win(win), .lose(lose),
        .Load_S(Load_S), .score_in(score_in), .Load_F(Load_F), .fruits_in(fruits_in),
        .Load_L(Load_L), .lives_in(lives_in), .score_out(score_out),
        .fruits_out(fruits_out), .lives_out(lives_out), .counter(counter),
        .seconds_left(seconds_left), .time_up(time_up), .running(running)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reload();
        m_phase   = PH_IDLE;
        m_counter = FULL;
        m_score   = 0;
        m_fruits  = 0;
        m_lives   = 0;
        m_time_up = 1'b0;
    endtask

    // A round: frames tick down while playing; a life loss pauses; any win/lose/timeout ends it.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n || restart) begin
            model_reload();
        end else begin
            if (Load_S) m_score = int'(score_in);
            if (Load_F) m_fruits = m_fruits | int'(fruits_in);
            if (Load_L) m_lives = (lives_in > 8'd3) ? 3 : int'(lives_in);
            m_time_up = 1'b0;
            if (m_phase == PH_IDLE && start) begin
                m_phase = PH_RUN;
            end else if (m_phase == PH_RUN || m_phase == PH_HOLD) begin
                if (win || lose) m_phase = PH_OVER;
                else if (lifeDown) m_phase = PH_HOLD;
                else if (m_phase == PH_HOLD) m_phase = PH_RUN;
                else if (frame_tick && m_counter > 0) begin
                    m_counter = m_counter - 1;
                    if (m_counter == 0) begin
                        m_time_up = 1'b1;
                        m_phase   = PH_OVER;
                    end
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (armed) begin
            chk("m_counter", counter, m_counter);
            chk("m_seconds", seconds_left, (m_counter + FPS - 1) / FPS);
            chk("m_time_up", time_up, m_time_up);
            chk("m_running", running, m_phase == PH_RUN);
            chk("m_score", score_out, m_score);
            chk("m_fruits", fruits_out, m_fruits);
            chk("m_lives", lives_out, m_lives);
        end
    end

    task automatic clk1();
        @(posedge Clk);
        #1;
        frame_tick = 1'b0; start = 1'b0; restart = 1'b0; win = 1'b0; lose = 1'b0;
        Load_S = 1'b0; Load_F = 1'b0; Load_L = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            clk1();
        end
    endtask

    int sec_tbl[12] = '{3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0};

    initial begin
        #1 Reset_n = 1'b0;
        #1;
        chk("reset_counter", counter, 12);
        chk("reset_seconds", seconds_left, 3);
        chk("reset_running", running, 0);
        chk("reset_score", score_out, 0);
        armed = 1'b1;
        clk1();
        Reset_n = 1'b1;
        clk1();
        chk("idle_counter", counter, 12);

        // full round to expiry
        start = 1'b1;
        clk1();
        chk("start_running", running, 1);
        for (int i = 1; i <= 12; i++) begin
            frame_tick = 1'b1;
            clk1();
            chk("tick_counter", counter, 12 - i);
            chk("tick_seconds", seconds_left, sec_tbl[i-1]);
            chk("tick_time_up", time_up, i == 12);
        end
        ticks(1);
        chk("tick13_counter", counter, 0);
        chk("tick13_time_up", time_up, 0);
        chk("expired_running", running, 0);

        // hold during life loss
        restart = 1'b1;
        clk1();
        chk("restart_counter", counter, 12);
        start = 1'b1;
        clk1();
        ticks(5);
        chk("pre_hold_counter", counter, 7);
        lifeDown = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1;
            clk1();
            chk("hold_counter", counter, 7);
            chk("hold_seconds", seconds_left, 2);
            chk("hold_running", running, 0);
        end
        lifeDown = 1'b0;
        clk1();
        chk("resume_running", running, 1);
        ticks(1);
        chk("resume_counter", counter, 6);
        chk("resume_seconds", seconds_left, 2);

        // register loads
        Load_F = 1'b1; fruits_in = 4'b0001;
        clk1();
        chk("fruits_a", fruits_out, 4'b0001);
        Load_F = 1'b1; fruits_in = 4'b0100;
        clk1();
        chk("fruits_b", fruits_out, 4'b0101);
        Load_L = 1'b1; lives_in = 8'd7;
        clk1();
        chk("lives_sat", lives_out, 3);
        Load_L = 1'b1; lives_in = 8'd2;
        clk1();
        chk("lives_two", lives_out, 2);
        Load_S = 1'b1; score_in = 10'd150;
        clk1();
        chk("score_150", score_out, 150);
        Load_S = 1'b1; score_in = 10'd5; Load_F = 1'b1; fruits_in = 4'b1000;
        Load_L = 1'b1; lives_in = 8'd1;
        clk1();
        chk("multi_score", score_out, 5);
        chk("multi_fruits", fruits_out, 4'b1101);
        chk("multi_lives", lives_out, 1);

        // restart beats tick and load
        restart = 1'b1; frame_tick = 1'b1; Load_S = 1'b1; score_in = 10'd50;
        clk1();
        chk("rst_counter", counter, 12);
        chk("rst_score", score_out, 0);
        chk("rst_fruits", fruits_out, 0);
        chk("rst_running", running, 0);
        ticks(1);
        chk("idle_tick_ignored", counter, 12);

        // lose freezes timer
        start = 1'b1;
        clk1();
        ticks(3);
        lose = 1'b1;
        clk1();
        chk("lose_counter", counter, 9);
        ticks(3);
        chk("done_counter", counter, 9);
        start = 1'b1;
        clk1();
        chk("done_start_ignored", running, 0);
        restart = 1'b1;
        clk1();
        chk("done_restart_counter", counter, 12);
        start = 1'b1;
        clk1();
        chk("restart_start_running", running, 1);

        // asynchronous reset mid-round
        Load_S = 1'b1; score_in = 10'd100;
        clk1();
        ticks(7);
        chk("pre_reset_counter", counter, 5);
        chk("pre_reset_score", score_out, 100);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_counter", counter, 12);
        chk("async_seconds", seconds_left, 3);
        chk("async_score", score_out, 0);
        chk("async_running", running, 0);
        clk1();
        Reset_n = 1'b1;
        frame_tick = 1'b1;
        clk1();
        chk("post_reset_counter", counter, 12);
        clk1();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_state_regs.md
GAME_STATE_REGS -- requirements
Module: game_state_regs

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, frame_tick pulses per displayed second (range 1..255).
REQ-002 Parameter ROUND_SECONDS, default 120, round length in seconds (range 1..255).
REQ-003 Clk  input  1  sole clock; all state SHALL update on posedge Clk.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 start  input  1  one-cycle pulse; gameplay begins.
REQ-007 restart, lifeDown, win, lose  input  1 each  level controls from game_logic.
REQ-008 Load_S / score_in  input  1 / 10  score load strobe and value.
REQ-009 Load_F / fruits_in  input  1 / 4  fruit-eaten mask load strobe and value.
REQ-010 Load_L / lives_in  input  1 / 8  lives-lost load strobe and value.
REQ-011 score_out  output  10; fruits_out  output  4; lives_out  output  2: registered values fed back to game_logic.
REQ-012 counter  output  32  frames remaining in round; 0 means time expired.
REQ-013 seconds_left  output  8  whole seconds remaining, for HUD.
REQ-014 time_up  output  1  one-cycle pulse when counter reaches 0.
REQ-015 running  output  1  high only in state RUN.

Function
REQ-016 Timer FSM states SHALL be IDLE, RUN, HOLD, EXPIRED, DONE.
REQ-017 IDLE: counter = ROUND_SECONDS*FRAMES_PER_SEC, seconds_left = ROUND_SECONDS, prescaler = 0; start -> RUN.
REQ-018 RUN: on frame_tick, counter decrements by 1 and prescaler increments; when prescaler would reach FRAMES_PER_SEC it wraps to 0 and seconds_left decrements in the same cycle.
REQ-019 RUN, frame_tick with counter == 1: counter -> 0, seconds_left -> 0, time_up = 1 in the following cycle only, state -> EXPIRED.
REQ-020 RUN: lifeDown high -> HOLD; HOLD freezes counter, seconds_left and prescaler; lifeDown low -> RUN.
REQ-021 RUN or HOLD: win or lose high -> DONE; DONE and EXPIRED freeze all timer values until restart.
REQ-022 Priority per cycle SHALL be restart > win/lose > lifeDown > frame_tick.
REQ-023 restart high (any state) -> next cycle: IDLE reload values, score_out = 0, fruits_out = 0, lives_out = 0, time_up = 0; Load_* strobes in the same cycle SHALL be ignored.
REQ-024 Load_S: score_out <= score_in; no arithmetic in this block.
REQ-025 Load_F: fruits_out <= fruits_out | fruits_in (eaten bits are sticky; never cleared except by restart/reset).
REQ-026 Load_L: lives_out <= lives_in[1:0] if lives_in <= 3, else 3 (saturate).
REQ-027 Load strobes SHALL be accepted in every FSM state and are independent of each other; simultaneous strobes all take effect.
REQ-028 start outside IDLE SHALL be ignored; frame_tick outside RUN SHALL be ignored.
REQ-029 counter SHALL never wrap below 0; seconds_left SHALL equal ceil(counter / FRAMES_PER_SEC) at all times.
REQ-030 All outputs SHALL be registered; latency from any input to its output effect is exactly one Clk.

Reset
REQ-031 Reset_n low SHALL immediately (asynchronously) force IDLE, score_out = 0, fruits_out = 0, lives_out = 0, prescaler = 0, counter = ROUND_SECONDS*FRAMES_PER_SEC, seconds_left = ROUND_SECONDS, time_up = 0, running = 0.
REQ-032 Reset_n asserted mid-round SHALL discard the in-progress round; release is synchronous to Clk, first state change no earlier than the first posedge after release.

Verification (FRAMES_PER_SEC = 4, ROUND_SECONDS = 3)
REQ-033 Reset, start, 12 frame_ticks -> counter 12->0, seconds_left 3,3,3,2...; ends 0; time_up exactly one cycle after 12th tick; 13th tick leaves counter 0.
REQ-034 RUN, 5 ticks, lifeDown high across 3 ticks, lifeDown low, 1 tick -> counter 7 then 6, seconds_left 2 throughout, running low during hold.
REQ-035 Load_F 4'b0001 then Load_F 4'b0100 -> fruits_out 0001 then 0101; Load_L 8'd7 -> lives_out 3; Load_S 10'd150 -> score_out 150.
REQ-036 restart asserted together with frame_tick and Load_S 10'd50 in RUN -> next cycle IDLE, counter 12, score_out 0.
REQ-037 lose in RUN at counter 9 -> DONE, counter stays 9 under further ticks; restart -> IDLE counter 12; start -> RUN.
REQ-038 Reset_n pulsed low mid-RUN with score 100, counter 5 -> outputs at reset values without a clock edge.
